// File: rtl/hier_include_rr_arbiter_pkg.sv
// Shared types and constants for the hierIncludeTop shared-resource arbitration slice.
package hier_include_rr_arbiter_pkg;

    localparam int unsigned ANOTHER_SIZE       = 4;
    localparam int unsigned ARB_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RELEASE
    } arb_state_t;

    typedef logic [$clog2(ANOTHER_SIZE)-1:0] req_id_t;

endpackage

// File: rtl/hier_include_rr_arbiter_pick.sv
// Combinational rotating-priority picker: first set req bit after last, wrapping.
module hier_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned idx;
        logic [IW-1:0] idx_w;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx   = (32'(last) + i) % NUM_REQ;
            idx_w = IW'(idx);
            if (!valid && req[idx_w]) begin
                winner = idx_w;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hier_include_rr_arbiter.sv
// Round-robin sequencer sharing one nested resource among NUM_REQ requesters,
// with start/done handshake, watchdog abort and per-winner completion pulses.
module hier_include_rr_arbiter
    import hier_include_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = ANOTHER_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         cpl,
    output logic                       cpl_err,
    output logic                       res_start,
    output logic [$clog2(NUM_REQ)-1:0] res_sel,
    input  logic                       res_done,
    output logic                       res_abort,
    output logic                       busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] last_q, last_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_c;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    hier_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Same-cycle done beats the watchdog terminal count, so abort is gated by res_done.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        abort_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (res_done) begin
                    err_d   = 1'b0;
                    state_d = RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    abort_c = 1'b1;
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        cpl = '0;
        if ((state_q == START) || (state_q == BUSY)) gnt[sel_q] = 1'b1;
        if (state_q == RELEASE) cpl[sel_q] = 1'b1;
        cpl_err   = (state_q == RELEASE) && err_q;
        res_start = (state_q == START);
        res_abort = abort_c;
        res_sel   = sel_q;
        busy      = (state_q != IDLE);
    end

endmodule
